// File: rtl/lib_arbiter_pkg.sv
// Shared definitions for the pixel event scheduler: default geometry,
// scheduler state encoding and the default-width event word.
package lib_arbiter_pkg;

    localparam int DEF_ROWS     = 4;
    localparam int DEF_COLS     = 4;
    localparam int DEF_POLARITY = 2;
    localparam int DEF_TS_W     = 16;
    localparam int DEF_ROW_W    = $clog2(DEF_ROWS);
    localparam int DEF_COL_W    = $clog2(DEF_COLS);
    localparam int WIDTH        = DEF_TS_W + DEF_ROW_W + DEF_COL_W + DEF_POLARITY;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SEND,
        RELEASE
    } sched_state_t;

    typedef struct packed {
        logic [DEF_TS_W-1:0]     ts;
        logic [DEF_ROW_W-1:0]    row;
        logic [DEF_COL_W-1:0]    col;
        logic [DEF_POLARITY-1:0] pol;
    } evt_t;

endpackage

// File: rtl/lsb_priority_enc.sv
// Finds the lowest set bit of a mask; bit 0 wins.
module lsb_priority_enc #(
    parameter  int N     = 16,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     mask_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // NOTE: both outputs get a value before the loop, so no path leaves them unassigned and no latch is inferred.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pixel_event_scheduler.sv
// Round-based scheduler: snapshots active pixels, emits one event per pixel
// in ascending index order with a grant each, then pulses group release.
module pixel_event_scheduler
    import lib_arbiter_pkg::*;
#(
    parameter  int ROWS     = DEF_ROWS,
    parameter  int COLS     = DEF_COLS,
    parameter  int POLARITY = DEF_POLARITY,
    parameter  int TS_W     = DEF_TS_W,
    localparam int ROW_W    = $clog2(ROWS),
    localparam int COL_W    = $clog2(COLS),
    localparam int WIDTH    = TS_W + ROW_W + COL_W + POLARITY
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [ROWS-1:0][COLS-1:0][POLARITY-1:0] req_i,
    input  logic                                   evt_ready_i,
    output logic                                   evt_valid_o,
    output logic [WIDTH-1:0]                       evt_data_o,
    output logic [ROWS-1:0][COLS-1:0]              gnt_o,
    output logic                                   grp_release_o
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef struct packed {
        logic [TS_W-1:0]     ts;
        logic [ROW_W-1:0]    row;
        logic [COL_W-1:0]    col;
        logic [POLARITY-1:0] pol;
    } evt_word_t;

    // Row-major flattening puts pixel (r,c) at index r*COLS+c.
    logic [N-1:0][POLARITY-1:0] req_flat;
    logic [N-1:0]               active;
    assign req_flat = req_i;

    always_comb begin
        active = '0;
        for (int i = 0; i < N; i++) begin
            active[i] = |req_flat[i];
        end
    end

    sched_state_t     state_q, state_n;
    logic [N-1:0]     pending_q, pending_n;
    logic [TS_W-1:0]  round_ts_q, round_ts_n;
    logic [TS_W-1:0]  ts_cnt_q;
    logic [IDX_W-1:0] sel_q, sel_n;
    evt_word_t        evt_q, evt_n;
    logic             valid_q, valid_n;
    logic [N-1:0]     gnt_q, gnt_n;
    logic             rel_q, rel_n;

    logic             cand_found;
    logic [IDX_W-1:0] cand_idx;
    logic [31:0]      cand_ext;
    logic [N-1:0]     sel_mask;

    lsb_priority_enc #(.N(N)) u_enc (
        .mask_i  (pending_q & active),
        .found_o (cand_found),
        .idx_o   (cand_idx)
    );

    assign cand_ext = 32'(cand_idx);
    assign sel_mask = N'(1) << sel_q;

    always_comb begin
        state_n    = state_q;
        pending_n  = pending_q;
        round_ts_n = round_ts_q;
        sel_n      = sel_q;
        evt_n      = evt_q;
        valid_n    = valid_q;
        gnt_n      = '0;
        rel_n      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|active) begin
                    pending_n  = active;
                    round_ts_n = ts_cnt_q;
                    state_n    = SCAN;
                end
            end
            SCAN: begin
                if (!cand_found) begin
                    pending_n = '0;
                    state_n   = RELEASE;
                end else begin
                    evt_n.ts  = round_ts_q;
                    evt_n.row = ROW_W'(cand_ext / COLS);
                    evt_n.col = COL_W'(cand_ext % COLS);
                    evt_n.pol = req_flat[cand_idx];
                    sel_n     = cand_idx;
                    valid_n   = 1'b1;
                    state_n   = SEND;
                end
            end
            SEND: begin
                // The grant goes to the registered pixel even if its request has since dropped.
                if (evt_ready_i) begin
                    valid_n   = 1'b0;
                    gnt_n     = sel_mask;
                    pending_n = pending_q & ~sel_mask;
                    state_n   = |(pending_q & ~sel_mask) ? SCAN : RELEASE;
                end
            end
            RELEASE: begin
                rel_n   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            round_ts_q <= '0;
            ts_cnt_q   <= '0;
            sel_q      <= '0;
            evt_q      <= '0;
            valid_q    <= 1'b0;
            gnt_q      <= '0;
            rel_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            pending_q  <= pending_n;
            round_ts_q <= round_ts_n;
            ts_cnt_q   <= ts_cnt_q + TS_W'(1);
            sel_q      <= sel_n;
            evt_q      <= evt_n;
            valid_q    <= valid_n;
            gnt_q      <= gnt_n;
            rel_q      <= rel_n;
        end
    end

    assign evt_valid_o   = valid_q;
    assign evt_data_o    = evt_q;
    assign gnt_o         = gnt_q;
    assign grp_release_o = rel_q;

endmodule

// File: tb/tb_pixel_event_scheduler.sv
// Self-checking bench for pixel_event_scheduler: table-driven rounds plus
// hand-written latency, backpressure, mid-round, wrap and reset sequences.
module tb_pixel_event_scheduler;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int POL   = 2;
    localparam int TS_W  = 4;
    localparam int N     = ROWS * COLS;
    localparam int WIDTH = TS_W + 2 + 2 + POL;

    logic                       clk_i = 1'b0;
    logic                       reset_i;
    logic [N-1:0][POL-1:0]      req_flat;
    logic                       evt_ready_i;
    logic                       evt_valid_o;
    logic [WIDTH-1:0]           evt_data_o;
    logic [ROWS-1:0][COLS-1:0]  gnt_o;
    logic                       grp_release_o;

    always #5 clk_i = ~clk_i;

    pixel_event_scheduler #(
        .ROWS(ROWS), .COLS(COLS), .POLARITY(POL), .TS_W(TS_W)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .req_i         (req_flat),
        .evt_ready_i   (evt_ready_i),
        .evt_valid_o   (evt_valid_o),
        .evt_data_o    (evt_data_o),
        .gnt_o         (gnt_o),
        .grp_release_o (grp_release_o)
    );

    typedef struct {
        logic [TS_W-1:0] ts;
        int              idx;
        logic [1:0]      pol;
    } exp_t;

    typedef struct {
        logic [N-1:0][POL-1:0] req;
        int                    exp_n;
        int                    exp_idx[4];
    } vec_t;

    exp_t            sb[$];
    vec_t            vecs[4];
    int              total = 0;
    int              bad = 0;
    int              gnt_seen = 0;
    int              rel_seen = 0;
    logic [TS_W-1:0] model_ts;

    // Reference timestamp: counts edges since reset release.
    always @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) model_ts <= '0;
        else          model_ts <= model_ts + 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] pack_evt(input exp_t e);
        return {e.ts, 2'(e.idx / COLS), 2'(e.idx % COLS), e.pol};
    endfunction

    task automatic push(input logic [TS_W-1:0] ts, input int idx);
        exp_t e;
        e.ts  = ts;
        e.idx = idx;
        e.pol = req_flat[idx];
        sb.push_back(e);
    endtask

    // One clock: capture a pending handshake, advance, then score outputs.
    task automatic step();
        logic             hs;
        logic [WIDTH-1:0] hs_data;
        logic [N-1:0]     g;
        exp_t             e;
        hs      = evt_valid_o && evt_ready_i;
        hs_data = evt_data_o;
        @(posedge clk_i);
        #1;
        g = gnt_o;
        if (hs) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got %0h expected none", hs_data);
            end else begin
                e = sb.pop_front();
                check("evt_data", 32'(hs_data), 32'(pack_evt(e)));
                check("gnt_onehot", 32'(g), 32'(1) << e.idx);
                req_flat[e.idx] = '0;
            end
        end else if (g != '0) begin
            check("gnt_spurious", 32'(g), 0);
        end
        if (g != '0) gnt_seen++;
        if (grp_release_o) begin
            rel_seen++;
            if (g != '0) check("rel_gnt_overlap", 32'(g), 0);
        end
        if (evt_valid_o && g != '0) check("valid_gnt_overlap", 32'(g), 0);
    endtask

    task automatic run_round(input string name);
        int r0 = rel_seen;
        int k  = 0;
        while (rel_seen == r0 && k < 60) begin
            step();
            k++;
        end
        check({name, "_release_seen"}, 32'(rel_seen - r0), 1);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!evt_valid_o && k < 10) begin
            step();
            k++;
        end
        check({name, "_valid_seen"}, 32'(evt_valid_o), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] held;
        int               g0;
        int               r0;
        int               k;

        foreach (vecs[v]) begin
            vecs[v].req = '0;
            vecs[v].exp_n = 0;
            vecs[v].exp_idx = '{0, 0, 0, 0};
        end
        vecs[0].req[15] = 2'b10; vecs[0].req[1] = 2'b01; vecs[0].req[8] = 2'b01;
        vecs[0].exp_n = 3; vecs[0].exp_idx = '{1, 8, 15, 0};
        vecs[1].req[0] = 2'b11;
        vecs[1].exp_n = 1; vecs[1].exp_idx = '{0, 0, 0, 0};
        vecs[2].req[12] = 2'b01; vecs[2].req[3] = 2'b10; vecs[2].req[6] = 2'b11;
        vecs[2].exp_n = 3; vecs[2].exp_idx = '{3, 6, 12, 0};
        vecs[3].req[5] = 2'b10; vecs[3].req[10] = 2'b10;
        vecs[3].exp_n = 2; vecs[3].exp_idx = '{5, 10, 0, 0};

        reset_i     = 1'b0;
        req_flat    = '0;
        evt_ready_i = 1'b1;
        step();
        step();
        check("rst_valid", 32'(evt_valid_o), 0);
        check("rst_data", 32'(evt_data_o), 0);
        check("rst_gnt", 32'(gnt_o), 0);
        check("rst_rel", 32'(grp_release_o), 0);
        reset_i = 1'b1;
        step();

        // Single pixel [1][2]: exact edge-by-edge latency.
        req_flat[6] = 2'b01;
        push(model_ts, 6);
        step();
        check("sp_e1_valid", 32'(evt_valid_o), 0);
        step();
        check("sp_e2_valid", 32'(evt_valid_o), 1);
        step();
        check("sp_e3_gnt", 32'(gnt_o), 32'(1) << 6);
        check("sp_e3_rel", 32'(grp_release_o), 0);
        step();
        check("sp_e4_rel", 32'(grp_release_o), 1);
        check("sp_e4_gnt", 32'(gnt_o), 0);
        step();
        check("sp_e5_rel", 32'(grp_release_o), 0);
        check("sp_sb_empty", 32'(sb.size()), 0);

        for (int v = 0; v < 4; v++) begin
            logic [TS_W-1:0] ts;
            req_flat = vecs[v].req;
            ts = model_ts;
            for (int i = 0; i < vecs[v].exp_n; i++) push(ts, vecs[v].exp_idx[i]);
            g0 = gnt_seen;
            r0 = rel_seen;
            run_round("vec");
            check("vec_grants", 32'(gnt_seen - g0), 32'(vecs[v].exp_n));
            check("vec_sb_empty", 32'(sb.size()), 0);
            step(); step(); step();
            check("vec_one_release", 32'(rel_seen - r0), 1);
        end

        // Backpressure on pixel [2][1].
        evt_ready_i  = 1'b0;
        req_flat[9]  = 2'b10;
        push(model_ts, 9);
        wait_valid("bp");
        held = evt_data_o;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid_hold", 32'(evt_valid_o), 1);
            check("bp_data_hold", 32'(evt_data_o), 32'(held));
            check("bp_no_gnt", 32'(gnt_o), 0);
        end
        evt_ready_i = 1'b1;
        step();
        check("bp_gnt", 32'(gnt_o), 32'(1) << 9);
        run_round("bp");
        check("bp_sb_empty", 32'(sb.size()), 0);

        // Mid-round: [1][1] arrives during SEND, [0][3] drops before its SCAN.
        req_flat[0] = 2'b01;
        req_flat[3] = 2'b01;
        push(model_ts, 0);
        wait_valid("mid");
        req_flat[5] = 2'b01;
        req_flat[3] = 2'b00;
        g0 = gnt_seen;
        run_round("mid_r1");
        check("mid_r1_grants", 32'(gnt_seen - g0), 1);
        push(model_ts, 5);
        run_round("mid_r2");
        check("mid_sb_empty", 32'(sb.size()), 0);

        // Timestamp wrap: snapshot at 15, then at a wrapped value.
        k = 0;
        while (model_ts != 4'hF && k < 20) begin
            step();
            k++;
        end
        req_flat[2] = 2'b01;
        push(4'hF, 2);
        run_round("wrap1");
        req_flat[7] = 2'b10;
        push(model_ts, 7);
        run_round("wrap2");
        check("wrap_sb_empty", 32'(sb.size()), 0);
        check("wrap_no_x", 32'($isunknown(evt_data_o)), 0);

        // Reset while an event is in flight.
        req_flat[10] = 2'b01;
        push(model_ts, 10);
        wait_valid("rst");
        reset_i = 1'b0;
        #1;
        check("rst_mid_valid", 32'(evt_valid_o), 0);
        check("rst_mid_gnt", 32'(gnt_o), 0);
        check("rst_mid_rel", 32'(grp_release_o), 0);
        check("rst_mid_data", 32'(evt_data_o), 0);
        sb.delete();
        step();
        step();
        check("rst_hold_valid", 32'(evt_valid_o), 0);
        reset_i = 1'b1;
        push(4'h0, 10);
        run_round("rst_new");
        check("rst_sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
